mem_access_ctrl: RTL and testbench

Initiator side of the data_memory port. Accepts single-byte LOAD/STORE requests and multi-byte COPY/FILL block requests over a valid/ready handshake, then sequences address, write_enable and data_in toward data_memory, sampling its combinational data_out. Sits between the core/control path and data_memory. The pair forms a small block-move engine.

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/xfer_counter.sv | 34 +++
 rtl/mem_access_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings and defaults for the memory access controller
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STORE = 3'd2,
        S_CP_RD = 3'd3,
        S_CP_WR = 3'd4,
        S_FILL  = 3'd5,
        S_DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/xfer_counter.sv
// rtl/xfer_counter.sv - byte offset / remaining-count tracker for block operations
module xfer_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] len_i,
    input  logic         step_i,
    output logic [W-1:0] offset_o,
    output logic         last_o
);

    logic [W-1:0] offset_q;
    logic [W-1:0] remain_q;

    // Load restarts at offset 0 with the full length; each step advances one byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            offset_q <= '0;
            remain_q <= '0;
        end else if (load_i) begin
            offset_q <= '0;
            remain_q <= len_i;
        end else if (step_i) begin
            offset_q <= offset_q + W'(1);
            remain_q <= remain_q - W'(1);
        end
    end

    assign offset_o = offset_q;
    assign last_o   = (remain_q == W'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - initiator sequencing LOAD/STORE/COPY/FILL onto data_memory
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [ADDR_W-1:0] req_src_i,
    input  logic [ADDR_W-1:0] req_len_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              busy_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] src_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] offset;
    logic              last;
    logic              accept;
    logic              cnt_step;

    // Ready is forced low while reset is held so nothing is accepted during reset.
    assign req_ready_o = rst_ni && (state_q == S_IDLE);
    assign busy_o      = !req_ready_o;
    assign accept      = req_ready_o && req_valid_i;
    assign cnt_step    = (state_q == S_FILL) || (state_q == S_CP_WR);
    assign rsp_valid_o = (state_q == S_DONE);
    assign rsp_rdata_o = rdata_q;

    xfer_counter #(.W(ADDR_W)) u_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (accept),
        .len_i    (req_len_i),
        .step_i   (cnt_step),
        .offset_o (offset),
        .last_o   (last)
    );

    // Main sequencer: latches the request and walks through the per-op states.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            src_q   <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr_i;
                        src_q   <= req_src_i;
                        wdata_q <= req_wdata_i;
                        case (req_op_i)
                            OP_LOAD:  state_q <= S_LOAD;
                            OP_STORE: state_q <= S_STORE;
                            OP_COPY:  state_q <= (req_len_i == '0) ? S_DONE : S_CP_RD;
                            default:  state_q <= (req_len_i == '0) ? S_DONE : S_FILL;
                        endcase
                    end
                end
                S_LOAD: begin
                    rdata_q <= mem_rdata_i;
                    state_q <= S_DONE;
                end
                S_STORE: state_q <= S_DONE;
                S_FILL: begin
                    if (last) state_q <= S_DONE;
                end
                S_CP_RD: begin
                    buf_q   <= mem_rdata_i;
                    state_q <= S_CP_WR;
                end
                S_CP_WR: begin
                    if (last) begin
                        rdata_q <= buf_q;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_CP_RD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory port is decoded purely from registered state; idle drives all zeros.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            S_LOAD: mem_addr_o = addr_q;
            S_STORE: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
            end
            S_FILL: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q + offset;
                mem_wdata_o = wdata_q;
            end
            S_CP_RD: mem_addr_o = src_q + offset;
            S_CP_WR: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q + offset;
                mem_wdata_o = buf_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam logic [1:0] LD = 2'b00;
    localparam logic [1:0] ST = 2'b01;
    localparam logic [1:0] CP = 2'b10;
    localparam logic [1:0] FL = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] src;
        logic [7:0] len;
        logic [7:0] wdata;
        int         exp_lat;
        bit         chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_src = 8'h00;
    logic [7:0] req_len = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [256];
    logic       mem_clr = 1'b1;
    ent_t       trace [$];
    int         errors = 0;
    int         checks = 0;
    vec_t       vecs [14];

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_addr_i  (req_addr),
        .req_src_i   (req_src),
        .req_len_i   (req_len),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .busy_o      (busy),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (rst_n && busy && !rsp_valid)
            trace.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ent_t exp_ent(input vec_t v, input int j, input logic [7:0] cur_wd);
        ent_t e;
        e.wdata = 8'h00;
        case (v.op)
            LD: begin e.we = 1'b0; e.addr = v.addr; end
            ST: begin e.we = 1'b1; e.addr = v.addr; e.wdata = v.wdata; end
            FL: begin e.we = 1'b1; e.addr = v.addr + 8'(j); e.wdata = v.wdata; end
            default: begin
                e.we   = j[0];
                e.addr = j[0] ? v.addr + 8'(j / 2) : v.src + 8'(j / 2);
                e.wdata = j[0] ? cur_wd : 8'h00;
            end
        endcase
        return e;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        int lat;
        int exp_n;
        ent_t e;
        trace.delete();
        @(negedge clk);
        req_op = v.op; req_addr = v.addr; req_src = v.src;
        req_len = v.len; req_wdata = v.wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk($sformatf("v%0d accept timeout", idx), 32'd1, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 600) begin @(negedge clk); lat++; end
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        if (v.chk_rd) chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rd);
        exp_n = (v.op == LD || v.op == ST) ? 1 : (v.op == FL ? int'(v.len) : 2 * int'(v.len));
        chk($sformatf("v%0d mem cycles", idx), trace.size(), exp_n);
        for (int j = 0; j < trace.size() && j < exp_n; j++) begin
            e = exp_ent(v, j, trace[j].wdata);
            chk($sformatf("v%0d cyc%0d we", idx, j), trace[j].we, e.we);
            chk($sformatf("v%0d cyc%0d addr", idx, j), trace[j].addr, e.addr);
            if (e.we) chk($sformatf("v%0d cyc%0d wdata", idx, j), trace[j].wdata, e.wdata);
        end
        @(negedge clk);
        chk($sformatf("v%0d rsp one cycle", idx), rsp_valid, 1'b0);
        chk($sformatf("v%0d ready after", idx), req_ready, 1'b1);
    endtask

    initial begin
        int n;
        int rsp_cnt;
        int wr_cnt;

        vecs[0]  = '{ST, 8'h10, 8'h00, 8'h00, 8'hA5, 2, 1'b1, 8'h00};
        vecs[1]  = '{LD, 8'h10, 8'h00, 8'h00, 8'h00, 2, 1'b1, 8'hA5};
        vecs[2]  = '{ST, 8'h02, 8'h00, 8'h00, 8'hC7, 2, 1'b1, 8'hA5};
        vecs[3]  = '{ST, 8'h20, 8'h00, 8'h00, 8'h11, 2, 1'b0, 8'h00};
        vecs[4]  = '{ST, 8'h21, 8'h00, 8'h00, 8'h22, 2, 1'b0, 8'h00};
        vecs[5]  = '{ST, 8'h22, 8'h00, 8'h00, 8'h33, 2, 1'b0, 8'h00};
        vecs[6]  = '{FL, 8'hFE, 8'h00, 8'h04, 8'h3C, 5, 1'b0, 8'h00};
        vecs[7]  = '{LD, 8'h02, 8'h00, 8'h00, 8'h00, 2, 1'b1, 8'hC7};
        vecs[8]  = '{CP, 8'h40, 8'h20, 8'h03, 8'h00, 7, 1'b1, 8'h33};
        vecs[9]  = '{CP, 8'h50, 8'h20, 8'h00, 8'h00, 1, 1'b0, 8'h00};
        vecs[10] = '{FL, 8'h51, 8'h00, 8'h00, 8'h99, 1, 1'b0, 8'h00};
        vecs[11] = '{LD, 8'h41, 8'h00, 8'h00, 8'h00, 2, 1'b1, 8'h22};
        vecs[12] = '{LD, 8'h00, 8'h00, 8'h00, 8'h00, 2, 1'b1, 8'h3C};
        vecs[13] = '{LD, 8'h50, 8'h00, 8'h00, 8'h00, 2, 1'b1, 8'h00};

        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        chk("reset ready", req_ready, 1'b0);
        chk("reset busy", busy, 1'b1);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset mem_we", mem_we, 1'b0);
        chk("reset mem_addr", mem_addr, 8'h00);
        rst_n = 1'b1;
        #1;
        chk("post-reset ready", req_ready, 1'b1);
        chk("post-reset rsp_rdata", rsp_rdata, 8'h00);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        chk("fill mem[FE]", mem[8'hFE], 8'h3C);
        chk("fill mem[01]", mem[8'h01], 8'h3C);
        chk("fill mem[02] untouched", mem[8'h02], 8'hC7);
        chk("copy mem[40]", mem[8'h40], 8'h11);
        chk("copy mem[42]", mem[8'h42], 8'h33);
        chk("len0 mem[51]", mem[8'h51], 8'h00);

        // Request held while a COPY is in flight: FILL must wait, then run once.
        trace.delete();
        @(negedge clk);
        chk("hold start ready", req_ready, 1'b1);
        req_op = CP; req_addr = 8'h60; req_src = 8'h40; req_len = 8'h02; req_valid = 1'b1;
        @(negedge clk);
        req_op = FL; req_addr = 8'h80; req_len = 8'h02; req_wdata = 8'h77;
        n = 1;
        rsp_cnt = 0;
        while (!req_ready && n < 50) begin
            if (rsp_valid) rsp_cnt++;
            @(negedge clk);
            n++;
        end
        chk("hold accept cycle", n, 6);
        chk("hold copy rsp count", rsp_cnt, 1);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) rsp_cnt++;
            @(negedge clk);
        end
        chk("hold fill rsp count", rsp_cnt, 1);
        wr_cnt = 0;
        foreach (trace[j]) if (trace[j].we && trace[j].addr >= 8'h80) wr_cnt++;
        chk("hold fill writes", wr_cnt, 2);
        chk("hold copy mem[61]", mem[8'h61], 8'h22);
        chk("hold fill mem[81]", mem[8'h81], 8'h77);
        chk("hold fill mem[82]", mem[8'h82], 8'h00);

        // Reset mid-FILL after three writes.
        @(negedge clk);
        req_op = FL; req_addr = 8'h90; req_len = 8'h08; req_wdata = 8'hE1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        wr_cnt = 0;
        while (wr_cnt < 3 && n < 50) begin
            if (mem_we) wr_cnt++;
            if (wr_cnt < 3) @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort mem_we", mem_we, 1'b0);
        chk("abort ready", req_ready, 1'b0);
        chk("abort rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort ready after release", req_ready, 1'b1);
        rsp_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        chk("abort no rsp", rsp_cnt, 0);
        chk("abort mem[92]", mem[8'h92], 8'hE1);
        chk("abort mem[93]", mem[8'h93], 8'h00);
        chk("abort rsp_rdata", rsp_rdata, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
